if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Parametrised IF->ID decoupling queue replacing the single-entry IF/ID latch.
//  Buffers up to DEPTH fetched {pc,inst} pairs in a circular FIFO with valid/ready handshakes on both sides.
//  An EX-stage branch flush empties it in one cycle.
//  When the queue is empty, ID sees a bubble of all-zero pc/inst.
// PARAMETERS
//  ADDR_W  32  width of instruction address (pc)
//  INST_W  32  width of instruction word
//  DEPTH   4   entry count; power of two, >=2
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst          in   1              synchronous, active-high reset
//  flush_i      in   1              branch/jump taken in EX; discard all entries
//  if_valid_i   in   1              IF presents a fetched instruction
//  if_pc_i      in   ADDR_W         pc of fetched instruction
//  if_inst_i    in   INST_W         fetched instruction word
//  if_ready_o   out  1              queue can accept (= !full)
//  id_valid_o   out  1              head entry available to ID (= !empty)
//  id_ready_i   in   1              ID consumes head this cycle
//  id_pc_o      out  ADDR_W         head pc; 0 when empty
//  id_inst_o    out  INST_W         head inst; 0 (bubble) when empty
//  count_o      out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=0, count=0.
//    Reset outputs: id_valid_o=0, id_pc_o=0, id_inst_o=0, if_ready_o=1, count_o=0.
//  - Reset dominates flush. Reset mid-stream drops all entries; storage contents are don't-care.
//  - push = if_valid_i & if_ready_o; pop = id_valid_o & id_ready_i.
//  - Latency: an entry pushed into an empty queue appears on id_* the next cycle. No same-cycle bypass.
//  - push&pop same cycle: both pointers advance, count unchanged. Legal at any occupancy 1..DEPTH-1.
//  - Full: if_ready_o=0, so a push is ignored even if a pop occurs the same cycle.
//    Full-queue behaviour is deliberately non-combinational; IF must hold its data.
//  - Empty: id_valid_o=0, and id_pc_o/id_inst_o are forced to 0. A pop cannot occur.
//  - flush_i=1: next cycle count=0 and pointers=0. Any same-cycle push or pop is discarded.
//    IF must refetch from the redirect target.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register disambiguates full vs empty.
//  - Invariant: count_o == (wr_ptr-rd_ptr) mod DEPTH, except when count_o==DEPTH.
//  - Outputs are combinational from registered state only (head mux). No input->output comb paths.
// CONFIGURATION
//  `IF_ID_QUEUE_STATS_EN defined: adds two outputs.
//    flush_cnt_o [31:0] counts cycles where flush_i=1.
//    stall_cnt_o [31:0] counts cycles where id_valid_o & !id_ready_i.
//    Both counters reset to 0 on rst, wrap at 2^32, and are not cleared by flush.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared include defines.v gains IFQ_DEPTH (default queue depth) and IFQ_CNT_W.
//    Existing ZeroWord/InstAddrBus/InstBus constants are reused for the default widths and the bubble value.
//  - One sub-module: if_id_queue_mem, a DEPTH x (ADDR_W+INST_W) register array.
//    It has a write port and an async read port; pointers and count remain in the top level.
// TESTING
//  1. rst=1 for 2 cycles -> count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, if_ready_o=1.
//  2. Push pc 0x0,0x4,0x8,0xC with id_ready_i=0 (DEPTH=4).
//     -> count_o=4, if_ready_o=0.
//     -> A 5th push (pc 0x10) is rejected; draining yields 0x0,0x4,0x8,0xC in order.
//  3. Continuous push+pop for 20 cycles from count=2 -> count_o stays 2.
//     Pointers wrap at least 4 times; the pc sequence out equals the sequence in.
//  4. count=3, and flush_i=1 with if_valid_i=1 (pc 0x40) in the same cycle.
//     -> Next cycle count_o=0 and id_inst_o=0; pc 0x40 never appears at the output.
//  5. Empty queue: push pc 0x100 at cycle t with id_ready_i=1.
//     -> id_valid_o=1 and id_pc_o=0x100 at t+1 (not t). Popped at t+1; empty at t+2.
//  6. Under the stats macro: hold id_ready_i=0 for 5 cycles with count>0, then pulse flush twice.
//     -> stall_cnt_o=5, flush_cnt_o=2.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF->ID decoupling queue.
// Carries the default pipeline widths and the bubble value used across the core.
// Imported by if_id_queue and if_id_queue_mem.
package if_id_queue_pkg;

    // Default instruction address / instruction word widths for the core.
    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    // Value ID sees on pc/inst when no instruction is available (bubble).
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Default IF->ID queue depth and the matching occupancy counter width.
    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_CNT_W = $clog2(IFQ_DEPTH) + 1;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// Purpose: DEPTH x WIDTH register array holding queued {pc,inst} entries.
// Latency: write lands on the rising edge; read port is asynchronous (0 cycles).
// Backpressure: none; the caller only asserts we when the queue accepts an entry.
module if_id_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    // Storage is not reset: occupancy lives in the parent, so stale entries are never observed.
    logic [WIDTH-1:0] mem [DEPTH];

    // Capture the incoming entry at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so ID sees it in the same cycle it becomes valid.
    assign rdata = mem[raddr];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// Purpose: IF->ID decoupling FIFO of DEPTH {pc,inst} entries, flushable in one cycle.
// Latency: an entry pushed at cycle t is presented to ID at t+1 (no bypass).
// Backpressure: if_ready_o = !full, registered-state only; IF must hold data while low.
// Optional stats: define IF_ID_QUEUE_STATS_EN to add flush_cnt_o / stall_cnt_o.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int DEPTH  = IFQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   if_valid_i,
    input  logic [ADDR_W-1:0]      if_pc_i,
    input  logic [INST_W-1:0]      if_inst_i,
    output logic                   if_ready_o,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [ADDR_W-1:0]      id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef IF_ID_QUEUE_STATS_EN
    ,
    output logic [31:0]            flush_cnt_o,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointers wrap naturally modulo DEPTH (power of two); count tells full from empty.
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [ENT_W-1:0] wr_ent;
    logic [ENT_W-1:0] rd_ent;
    logic [ADDR_W-1:0] rd_pc;
    logic [INST_W-1:0] rd_inst;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready/valid come from registered count only, so a pop cannot free a slot for a same-cycle push.
    assign push = if_valid_i & ~full;
    assign pop  = ~empty & id_ready_i;

    assign wr_ent = {if_pc_i, if_inst_i};

    // A write during flush lands in a slot that is immediately considered free, so no gating is needed.
    if_id_queue_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENT_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_ent),
        .raddr (rd_ptr),
        .rdata (rd_ent)
    );

    assign {rd_pc, rd_inst} = rd_ent;

    // Pointer and occupancy update; reset outranks flush, flush discards any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head mux: an empty queue presents a zero bubble instead of whatever stale data sits at rd_ptr.
    always_comb begin
        id_valid_o = ~empty;
        if_ready_o = ~full;
        count_o    = count;
        id_pc_o    = ADDR_W'(ZERO_WORD);
        id_inst_o  = INST_W'(ZERO_WORD);
        if (!empty) begin
            id_pc_o   = rd_pc;
            id_inst_o = rd_inst;
        end
    end

`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] flush_cnt;
    logic [31:0] stall_cnt;

    // Free-running event counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (~empty & ~id_ready_i) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign flush_cnt_o = flush_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule : if_id_queue
